// File: rtl/desc_readback_if.sv
// rtl/desc_readback_if.sv - host/PE-grid handshake bundle for the descriptor readback engine
interface desc_readback_if #(
  parameter int NUM_ROWS       = 16,
  parameter int NUM_COL_GROUPS = 4,
  parameter int PIX_W          = 8
);
  localparam int ROW_W    = $clog2(NUM_ROWS);
  localparam int GRP_W    = $clog2(NUM_COL_GROUPS);
  localparam int WORD_W   = 4 * PIX_W;
  localparam int PIX_IN_W = 4 * 33;

  logic                start;
  logic [ROW_W-1:0]    rd_row;
  logic [GRP_W-1:0]    rd_col_group;
  logic [PIX_IN_W-1:0] pix_in;
  logic [WORD_W-1:0]   word_out;
  logic                word_valid;
  logic                word_ready;
  logic                busy;
  logic                done;
  logic                sat_flag;

  // Readback engine side: addresses the grid and sources the word stream.
  modport master (
    input  start, pix_in, word_ready,
    output rd_row, rd_col_group, word_out, word_valid, busy, done, sat_flag
  );

  // Parent/host side: kicks the run, muxes PE fields in, sinks words.
  modport slave (
    output start, pix_in, word_ready,
    input  rd_row, rd_col_group, word_out, word_valid, busy, done, sat_flag
  );
endinterface

// File: rtl/desc_readback.sv
// rtl/desc_readback.sv - streams the log2-domain PE descriptor back out as packed 8-bit pixels
// Optional feature macro: DESC_RB_SAT_EN (clamp out-of-range/negative fields to all-ones, sticky sat_flag).
module desc_readback #(
  parameter int NUM_ROWS       = 16,
  parameter int NUM_COL_GROUPS = 4,
  parameter int PIX_W          = 8
) (
  input logic             clk,
  input logic             rst,
  desc_readback_if.master rb_io
);
  localparam int ROW_W  = $clog2(NUM_ROWS);
  localparam int GRP_W  = $clog2(NUM_COL_GROUPS);
  localparam int WORD_W = 4 * PIX_W;
  localparam int FLD_W  = 33;
  localparam int FRAC_W = 27;
  // 1.f mantissa shifted left by up to 31 integer bits
  localparam int EXT_W  = 32 + FRAC_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            state_q;
  logic [ROW_W-1:0]  row_q;
  logic [GRP_W-1:0]  grp_q;
  logic [WORD_W-1:0] word_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic              sat_q;

  logic [WORD_W-1:0] word_d;
  logic [3:0]        pix_sat;
  logic              sat_d;
  logic              last_addr;

  // Per-pixel antilog: field layout is {sign, int[4:0], frac[-1:-27]}.
  // The integer part is the exponent; shifting the 1.f mantissa left by it
  // and dropping the fraction gives (1<<e) | f[-1:-e].
  for (genvar i = 0; i < 4; i++) begin : g_pix
    logic [FLD_W-1:0]  fld;
    logic [4:0]        exp_v;
    logic [FRAC_W-1:0] frac;
    logic [EXT_W-1:0]  ext;
    logic              ovf;
    logic [PIX_W-1:0]  pix;
    logic              unused_bits;

    // pe[4g] sits in the top slice of pix_in and lands in the top byte of the word
    assign fld   = rb_io.pix_in[(3-i)*FLD_W +: FLD_W];
    assign exp_v = fld[31:27];
    assign frac  = fld[26:0];
    assign ext   = {{(EXT_W-FRAC_W-1){1'b0}}, 1'b1, frac} << exp_v;

`ifdef DESC_RB_SAT_EN
    assign ovf = fld[32] | (int'(exp_v) >= PIX_W);
`else
    assign ovf = 1'b0;
`endif

    // All-zero magnitude is the PE reset state (and also pixel value 1): reads as 0.
    // The sign bit is excluded so a stray sign alone cannot fabricate a 1.
    assign pix = ovf ? {PIX_W{1'b1}}
               : (fld[31:0] == 32'd0) ? {PIX_W{1'b0}}
               : ext[FRAC_W +: PIX_W];

    assign word_d[(3-i)*PIX_W +: PIX_W] = pix;
    assign pix_sat[i] = ovf;
    // sign bit is only consumed in the saturating build; upper/lower ext bits are discarded
    assign unused_bits = ^{fld[32], ext};
  end

  assign sat_d     = |pix_sat;
  assign last_addr = (row_q == ROW_W'(NUM_ROWS - 1)) &&
                     (grp_q == GRP_W'(NUM_COL_GROUPS - 1));

  // Control FSM: fetch/decode one column group, hold it until the sink accepts, then advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      grp_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // start is only looked at here, so a pulse during a run is dropped
          if (rb_io.start) begin
            state_q <= S_FETCH;
            row_q   <= '0;
            grp_q   <= '0;
            busy_q  <= 1'b1;
            sat_q   <= 1'b0;
          end
        end
        S_FETCH: begin
          word_q  <= word_d;
          valid_q <= 1'b1;
          sat_q   <= sat_q | sat_d;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (rb_io.word_ready) begin
            valid_q <= 1'b0;
            if (last_addr) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              row_q   <= '0;
              grp_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              // column group is the fast index, matching the load order
              if (grp_q == GRP_W'(NUM_COL_GROUPS - 1)) begin
                grp_q <= '0;
                row_q <= row_q + ROW_W'(1);
              end else begin
                grp_q <= grp_q + GRP_W'(1);
              end
              state_q <= S_FETCH;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rb_io.rd_row       = row_q;
  assign rb_io.rd_col_group = grp_q;
  assign rb_io.word_out     = word_q;
  assign rb_io.word_valid   = valid_q;
  assign rb_io.busy         = busy_q;
  assign rb_io.done         = done_q;
  assign rb_io.sat_flag     = sat_q;

endmodule

// File: tb/tb_desc_readback.sv
// tb/tb_desc_readback.sv - self-checking bench for desc_readback (pixel-level model, directed runs)
module tb_desc_readback;
`ifdef DESC_RB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  desc_readback_if rb_if ();

  desc_readback dut (
    .clk   (clk),
    .rst   (rst),
    .rb_io (rb_if.master)
  );

  // PE grid contents (log2 fields) and the pixel values the host must see
  logic [32:0] pe   [16][16];
  logic [7:0]  ep   [16][16];
  bit          psat [16][16];
  logic [31:0] exp_word [64];
  bit          word_sat [64];

  int n_checks = 0;
  int n_fail   = 0;
  int k;
  bit prev_last;
  bit sat_seen;
  bit mon_en = 1'b0;
  int edges;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Load-path encoding of an 8-bit pixel: e = floor(log2 p), fraction = bits below the MSB.
  function automatic logic [32:0] enc(input int p);
    int e;
    logic [26:0] f;
    if (p == 0) return 33'd0;
    e = 0;
    for (int b = 0; b < 8; b++) if (((p >> b) & 1) != 0) e = b;
    f = 27'((p - (1 << e)) << (27 - e));
    return {1'b0, 5'(e), f};
  endfunction

  task automatic load_zero();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        pe[r][c] = 33'd0; ep[r][c] = 8'd0; psat[r][c] = 1'b0;
      end
  endtask

  task automatic load_ramp();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        int v;
        v = 16 * r + c;
        pe[r][c]   = enc(v);
        ep[r][c]   = (v == 1) ? 8'd0 : 8'(v);
        psat[r][c] = 1'b0;
      end
  endtask

  task automatic build_words();
    for (int w = 0; w < 64; w++) begin
      int r, g;
      r = w / 4; g = w % 4;
      exp_word[w] = {ep[r][4*g], ep[r][4*g+1], ep[r][4*g+2], ep[r][4*g+3]};
      word_sat[w] = psat[r][4*g] | psat[r][4*g+1] | psat[r][4*g+2] | psat[r][4*g+3];
    end
  endtask

  // PE grid read mux as seen by the parent
  always_comb begin
    int c0;
    c0 = int'(rb_if.rd_col_group) * 4;
    rb_if.pix_in = {pe[rb_if.rd_row][c0], pe[rb_if.rd_row][c0+1],
                    pe[rb_if.rd_row][c0+2], pe[rb_if.rd_row][c0+3]};
  end

  // Cycle-by-cycle compare against the word sequence model
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("done_pulse", rb_if.done, prev_last);
      prev_last = 1'b0;
      if (rb_if.word_valid) begin
        if (k >= 64) begin
          chk("extra_word_index", k, 63);
        end else begin
          chk($sformatf("word%0d", k), rb_if.word_out, exp_word[k]);
          chk($sformatf("rd_row_w%0d", k), rb_if.rd_row, k / 4);
          chk($sformatf("rd_grp_w%0d", k), rb_if.rd_col_group, k % 4);
          sat_seen = sat_seen | (SAT & word_sat[k]);
          if (rb_if.word_ready) begin
            prev_last = (k == 63);
            k++;
          end
        end
      end
      chk("sat_flag", rb_if.sat_flag, sat_seen);
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_row"},   rb_if.rd_row, 0);
    chk({tag, "_rd_grp"},   rb_if.rd_col_group, 0);
    chk({tag, "_word_out"}, rb_if.word_out, 0);
    chk({tag, "_valid"},    rb_if.word_valid, 0);
    chk({tag, "_busy"},     rb_if.busy, 0);
    chk({tag, "_done"},     rb_if.done, 0);
    chk({tag, "_sat"},      rb_if.sat_flag, 0);
  endtask

  // mode 0: ready high; 1: ready low 5 cycles on word 10; 2: extra start at word 20; 3: rst at word 30
  task automatic run(input int mode, output int n_edges);
    int hold;
    bit pulsed;
    hold = 0; pulsed = 1'b0;
    k = 0; prev_last = 1'b0; sat_seen = 1'b0;
    n_edges = 0;
    @(posedge clk); #1;
    rb_if.start = 1'b1; rb_if.word_ready = 1'b1;
    @(posedge clk); #1;
    rb_if.start = 1'b0; mon_en = 1'b1;
    while (n_edges < 400) begin
      @(negedge clk);
      if (n_edges == 0) begin
        chk("lat_busy_after_start", rb_if.busy, 1);
        chk("lat_valid_1cyc", rb_if.word_valid, 0);
      end
      if (n_edges == 1) chk("lat_valid_2cyc", rb_if.word_valid, 1);
      if (rb_if.done) break;
      @(posedge clk); #1;
      n_edges++;
      rb_if.start = 1'b0;
      if (mode == 1 && rb_if.word_valid && k == 10 && hold < 5) begin
        rb_if.word_ready = 1'b0; hold++;
      end else begin
        rb_if.word_ready = 1'b1;
      end
      if (mode == 2 && k == 20 && !pulsed) begin
        rb_if.start = 1'b1; pulsed = 1'b1;
      end
      if (mode == 3 && k == 30) begin
        rst = 1'b1; mon_en = 1'b0;
        break;
      end
    end
    if (n_edges >= 400) chk("run_timeout_edges", n_edges, 0);
    mon_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] f200;
    rst = 1'b1;
    rb_if.start = 1'b0;
    rb_if.word_ready = 1'b0;
    load_zero();
    build_words();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // T2: all PEs in reset state
    run(0, edges);
    chk("t2_edges", edges, 128);
    chk("t2_words", k, 64);

    // T1: ramp
    load_ramp();
    build_words();
    chk("model_word0", exp_word[0], 32'h00000203);
    chk("model_word5", exp_word[5], 32'h14151617);
    chk("model_word63", exp_word[63], 32'hFCFDFEFF);
    run(0, edges);
    chk("t1_edges", edges, 128);
    chk("t1_words", k, 64);
    @(negedge clk);
    chk("t1_busy_after_done", rb_if.busy, 0);
    chk("t1_valid_after_done", rb_if.word_valid, 0);

    // T3: backpressure on word 10
    run(1, edges);
    chk("t3_edges", edges, 133);
    chk("t3_words", k, 64);

    // T4: start during the run is ignored
    run(2, edges);
    chk("t4_edges", edges, 128);
    chk("t4_words", k, 64);
    repeat (4) begin
      @(negedge clk);
      chk("t4_idle_busy", rb_if.busy, 0);
      chk("t4_idle_valid", rb_if.word_valid, 0);
      chk("t4_idle_done", rb_if.done, 0);
    end

    // T5: reset in the middle of a run
    run(3, edges);
    chk("t5_k_at_reset", k, 30);
    @(negedge clk);
    check_reset_outputs("t5_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    run(0, edges);
    chk("t5_rerun_edges", edges, 128);
    chk("t5_rerun_words", k, 64);

    // T6: exponent 9 and a negative field
    pe[0][0]   = {1'b0, 5'd9, 27'd5 << 18};
    ep[0][0]   = SAT ? 8'hFF : 8'h05;
    psat[0][0] = SAT;
    f200       = enc(200);
    pe[0][1]   = {1'b1, f200[31:0]};
    ep[0][1]   = SAT ? 8'hFF : 8'hC8;
    psat[0][1] = SAT;
    build_words();
    chk("model_t6_word0", exp_word[0], SAT ? 32'hFFFF0203 : 32'h05C80203);
    run(0, edges);
    chk("t6_edges", edges, 128);
    chk("t6_words", k, 64);
    repeat (3) @(negedge clk);
    chk("t6_sat_sticky", rb_if.sat_flag, SAT);

    // Fresh run clears the sticky flag (monitor expects 0 from the first cycle)
    load_ramp();
    build_words();
    run(0, edges);
    chk("t6_clear_words", k, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
